dp_bus_arbiter: RTL and testbench
=================================

Name: dp_bus_arbiter

Overview:
Shares the processor datapath between two masters: the instruction control circuit (core) and a debug port that reads and writes the eight general registers.
Sits between the control circuit outputs and the datapath control inputs, and muxes the datapath's 16-bit external data input.
The core keeps ownership for a whole instruction. Ownership changes only at instruction boundaries.
A burst limit guarantees the core forward progress while debug traffic is pending.

Parameters:
DBG_BURST, 2, max consecutive debug transactions while core_req is high before the core must complete one instruction (1..15)
WDOG_CYCLES, 16, core grant watchdog limit in cycles (used only with ARB_WATCHDOG_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, synchronous, active-high
core_req  input  1  core has an instruction to execute; held high until core_last
core_last  input  1  final cycle of the current core instruction
core_gnt  output  1  core owns datapath; core stalls (done held low) while 0
core_ext_data  input  16  core external data
core_ext_data_en, core_alu_reg_en, core_alu_sel, core_alu_out_en, core_g_reg_en  input  1 each  core control signals
core_reg_in_en, core_reg_out_en  input  8 each  core one-hot register enables
dp_ext_data  output  16  to datapath ext_data
dp_ext_data_en, dp_alu_reg_en, dp_alu_sel, dp_alu_out_en, dp_g_reg_en  output  1 each  to datapath
dp_reg_in_en, dp_reg_out_en  output  8 each  to datapath
dp_bus  input  16  datapath shared bus value, sampled for debug reads
dbg_req  input  1  debug transaction request, level
dbg_we  input  1  1 = write, 0 = read; stable while dbg_req high
dbg_reg  input  3  target register index
dbg_wdata  input  16  write data
dbg_ack  output  1  one-cycle completion pulse
dbg_rdata  output  16  read data, valid from dbg_ack onward, held until next read
wdog_err  output  1  watchdog pulse (constant 0 without ARB_WATCHDOG_EN)

Behaviour:
- Reset: state IDLE, burst_cnt 0, dbg_rdata 0. All dp_* outputs, core_gnt, dbg_ack and wdog_err are 0.
- Reset mid-transaction aborts it. No dbg_ack is issued and no register write completes after the reset cycle.
- States: IDLE, CORE, DBG_XFER, DBG_ACK. All outputs are decoded from registered state. The only combinational paths are the core_* -> dp_* passthrough in CORE and the dbg_* -> dp_* drive in DBG_XFER.
- Arbitration decision, evaluated in IDLE and DBG_ACK:
  - if dbg_req and (burst_cnt < DBG_BURST or !core_req), go to DBG_XFER;
  - else if core_req, go to CORE;
  - else go to IDLE.
- CORE:
  - core_gnt=1 and every dp_* equals its core_* counterpart.
  - core_req is ignored while in CORE.
  - On core_last, burst_cnt clears to 0. Next state is DBG_XFER if dbg_req, else CORE if core_req, else IDLE.
  - Back-to-back core instructions therefore have no bubble when no debug request is pending.
- DBG_XFER (exactly 1 cycle), core_gnt=0:
  - Write: dp_ext_data=dbg_wdata, dp_ext_data_en=1, dp_reg_in_en=1<<dbg_reg.
  - Read: dp_reg_out_en=1<<dbg_reg, and dbg_rdata<=dp_bus at the clock edge.
  - All other dp_* are 0.
  - Next state is DBG_ACK. burst_cnt increments, saturating at 15.
- DBG_ACK: dbg_ack=1 and all dp_* are 0. If dbg_req is still high in this cycle it is treated as a new transaction.
- Outside CORE and DBG_XFER, all dp_* are 0.
- Latency: dbg_req rising while in IDLE gives DBG_XFER on the next cycle and dbg_ack the cycle after.
- Simultaneous dbg_req and core_req in IDLE with burst_cnt < DBG_BURST: debug wins.
- A debug request arriving mid-instruction waits for core_last. Worst-case wait is one full instruction.

Optional Feature:
- ARB_WATCHDOG_EN defined: a counter runs while in CORE and resets on entry and on core_last.
  - If it reaches WDOG_CYCLES without core_last: wdog_err pulses 1 cycle, core_gnt drops, state goes to IDLE, and burst_cnt clears.
  - Pending debug then proceeds per the normal arbitration rule.
- ARB_WATCHDOG_EN undefined: no counter; wdog_err tied 0; CORE holds until core_last indefinitely.

Test Plan:
1. rst high 2 cycles with all inputs toggling -> all outputs 0, dbg_rdata=0; first cycle after release, state IDLE.
2. Idle, dbg_req=1, dbg_we=1, dbg_reg=5, dbg_wdata=16'hBEEF -> next cycle dp_reg_in_en=8'h20, dp_ext_data_en=1, dp_ext_data=BEEF; following cycle dbg_ack=1.
3. Read dbg_reg=3 with dp_bus=16'h1234 during DBG_XFER -> dp_reg_out_en=8'h08; dbg_rdata=1234 with dbg_ack, held after.
4. Core in a 3-cycle instruction, dbg_req raised in cycle 1 -> dp_* follow core_* through core_last; DBG_XFER the cycle after core_last; core_gnt 0 there.
5. DBG_BURST=2, core_req and dbg_req held high -> pattern: 2 debug acks, 1 full core instruction, 2 debug acks, repeating.
6. ARB_WATCHDOG_EN, WDOG_CYCLES=16, core_last never asserted -> core_gnt drops and wdog_err pulses at the 16th CORE cycle; without macro, core_gnt stays 1 after 100 cycles.

Source files
------------

// File: rtl/dp_bus_arbiter.sv
// ----------------------------------------------------------------------------
// dp_bus_arbiter
//   Shares the processor datapath between the instruction control circuit
//   (core) and a debug port that reads/writes the eight general registers.
//   The core owns the datapath for a whole instruction. Ownership only
//   changes at instruction boundaries. A burst limit on consecutive debug
//   transactions guarantees the core forward progress.
//
//   Optional feature macro: ARB_WATCHDOG_EN
//     defined   -> a CORE-ownership watchdog forces the state back to IDLE
//                  after WDOG_CYCLES cycles without core_last and pulses
//                  wdog_err for one cycle.
//     undefined -> no watchdog, wdog_err is tied 0.
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   core_req/core_last    core instruction request / final instruction cycle
//   core_gnt              core owns the datapath
//   core_*                core datapath controls, passed through in CORE
//   dp_*                  datapath controls and external data
//   dp_bus                datapath shared bus, sampled on debug reads
//   dbg_req/we/reg/wdata  debug transaction request (level) and operands
//   dbg_ack               one-cycle completion pulse
//   dbg_rdata             last debug read value
//   wdog_err              watchdog expiry pulse
// ----------------------------------------------------------------------------
module dp_bus_arbiter #(
    parameter int DBG_BURST   = 2,
    parameter int WDOG_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_last,
    output logic        core_gnt,
    input  logic [15:0] core_ext_data,
    input  logic        core_ext_data_en,
    input  logic        core_alu_reg_en,
    input  logic        core_alu_sel,
    input  logic        core_alu_out_en,
    input  logic        core_g_reg_en,
    input  logic [7:0]  core_reg_in_en,
    input  logic [7:0]  core_reg_out_en,
    output logic [15:0] dp_ext_data,
    output logic        dp_ext_data_en,
    output logic        dp_alu_reg_en,
    output logic        dp_alu_sel,
    output logic        dp_alu_out_en,
    output logic        dp_g_reg_en,
    output logic [7:0]  dp_reg_in_en,
    output logic [7:0]  dp_reg_out_en,
    input  logic [15:0] dp_bus,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [2:0]  dbg_reg,
    input  logic [15:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [15:0] dbg_rdata,
    output logic        wdog_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CORE     = 2'd1,
        DBG_XFER = 2'd2,
        DBG_ACK  = 2'd3
    } state_t;

    localparam logic [3:0] BURST_LIM = 4'(DBG_BURST);

    state_t      state_q, state_d;
    logic [3:0]  burst_cnt_q, burst_cnt_d;
    logic [15:0] dbg_rdata_q, dbg_rdata_d;

    // Debug wins the arbitration unless it has used up its burst while the
    // core is waiting.
    logic arb_dbg;
    assign arb_dbg = dbg_req && ((burst_cnt_q < BURST_LIM) || !core_req);

`ifdef ARB_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

    logic [WW-1:0] wdog_cnt_q, wdog_cnt_d;
    logic          wdog_err_q, wdog_err_d;
    logic          wdog_hit;

    // wdog_cnt_q holds the number of completed CORE cycles of the current
    // instruction, so WDOG_LAST marks the WDOG_CYCLES-th CORE cycle.
    assign wdog_hit = (state_q == CORE) && !core_last && (wdog_cnt_q == WDOG_LAST);
`endif

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        dbg_rdata_d = dbg_rdata_q;
        case (state_q)
            IDLE, DBG_ACK: begin
                if (arb_dbg)       state_d = DBG_XFER;
                else if (core_req) state_d = CORE;
                else               state_d = IDLE;
            end
            CORE: begin
                if (core_last) begin
                    // Instruction boundary: the core made progress, so the
                    // debug burst budget is refilled.
                    burst_cnt_d = 4'd0;
                    if (dbg_req)       state_d = DBG_XFER;
                    else if (core_req) state_d = CORE;
                    else               state_d = IDLE;
                end
`ifdef ARB_WATCHDOG_EN
                else if (wdog_hit) begin
                    burst_cnt_d = 4'd0;
                    state_d     = IDLE;
                end
`endif
            end
            DBG_XFER: begin
                if (!dbg_we) dbg_rdata_d = dp_bus;
                if (burst_cnt_q != 4'd15) burst_cnt_d = burst_cnt_q + 4'd1;
                state_d = DBG_ACK;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ARB_WATCHDOG_EN
    always_comb begin
        wdog_err_d = wdog_hit;
        // Counter is zero outside CORE, which also clears it on entry.
        wdog_cnt_d = '0;
        if (state_q == CORE && !core_last && !wdog_hit)
            wdog_cnt_d = wdog_cnt_q + 1'b1;
    end
`endif

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            burst_cnt_q <= 4'd0;
            dbg_rdata_q <= 16'd0;
`ifdef ARB_WATCHDOG_EN
            wdog_cnt_q  <= '0;
            wdog_err_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            dbg_rdata_q <= dbg_rdata_d;
`ifdef ARB_WATCHDOG_EN
            wdog_cnt_q  <= wdog_cnt_d;
            wdog_err_q  <= wdog_err_d;
`endif
        end
    end

    // ---------------- outputs ----------------
    assign core_gnt  = (state_q == CORE);
    assign dbg_ack   = (state_q == DBG_ACK);
    assign dbg_rdata = dbg_rdata_q;
`ifdef ARB_WATCHDOG_EN
    assign wdog_err  = wdog_err_q;
`else
    assign wdog_err  = 1'b0;
`endif

    // Datapath drive: core passthrough in CORE, debug access in DBG_XFER,
    // quiet everywhere else.
    always_comb begin
        dp_ext_data    = 16'd0;
        dp_ext_data_en = 1'b0;
        dp_alu_reg_en  = 1'b0;
        dp_alu_sel     = 1'b0;
        dp_alu_out_en  = 1'b0;
        dp_g_reg_en    = 1'b0;
        dp_reg_in_en   = 8'd0;
        dp_reg_out_en  = 8'd0;
        case (state_q)
            CORE: begin
                dp_ext_data    = core_ext_data;
                dp_ext_data_en = core_ext_data_en;
                dp_alu_reg_en  = core_alu_reg_en;
                dp_alu_sel     = core_alu_sel;
                dp_alu_out_en  = core_alu_out_en;
                dp_g_reg_en    = core_g_reg_en;
                dp_reg_in_en   = core_reg_in_en;
                dp_reg_out_en  = core_reg_out_en;
            end
            DBG_XFER: begin
                if (dbg_we) begin
                    dp_ext_data    = dbg_wdata;
                    dp_ext_data_en = 1'b1;
                    dp_reg_in_en   = 8'd1 << dbg_reg;
                end else begin
                    dp_reg_out_en  = 8'd1 << dbg_reg;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dp_bus_arbiter.sv
module tb_dp_bus_arbiter;

    localparam int DBG_BURST   = 2;
    localparam int WDOG_CYCLES = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_last, core_gnt;
    logic [15:0] core_ext_data;
    logic        core_ext_data_en, core_alu_reg_en, core_alu_sel, core_alu_out_en, core_g_reg_en;
    logic [7:0]  core_reg_in_en, core_reg_out_en;
    logic [15:0] dp_ext_data;
    logic        dp_ext_data_en, dp_alu_reg_en, dp_alu_sel, dp_alu_out_en, dp_g_reg_en;
    logic [7:0]  dp_reg_in_en, dp_reg_out_en;
    logic [15:0] dp_bus;
    logic        dbg_req, dbg_we;
    logic [2:0]  dbg_reg;
    logic [15:0] dbg_wdata;
    logic        dbg_ack;
    logic [15:0] dbg_rdata;
    logic        wdog_err;

    dp_bus_arbiter #(.DBG_BURST(DBG_BURST), .WDOG_CYCLES(WDOG_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_last(core_last), .core_gnt(core_gnt),
        .core_ext_data(core_ext_data), .core_ext_data_en(core_ext_data_en),
        .core_alu_reg_en(core_alu_reg_en), .core_alu_sel(core_alu_sel),
        .core_alu_out_en(core_alu_out_en), .core_g_reg_en(core_g_reg_en),
        .core_reg_in_en(core_reg_in_en), .core_reg_out_en(core_reg_out_en),
        .dp_ext_data(dp_ext_data), .dp_ext_data_en(dp_ext_data_en),
        .dp_alu_reg_en(dp_alu_reg_en), .dp_alu_sel(dp_alu_sel),
        .dp_alu_out_en(dp_alu_out_en), .dp_g_reg_en(dp_g_reg_en),
        .dp_reg_in_en(dp_reg_in_en), .dp_reg_out_en(dp_reg_out_en),
        .dp_bus(dp_bus),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_reg(dbg_reg), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 0;

    // ---- reference model: who holds the datapath and where the debug
    //      transaction is (0 none, 1 transfer cycle, 2 ack cycle) ----
    bit          m_core;
    int          m_ph;
    int          m_burst;
    logic [15:0] m_rdata;
    bit          m_wderr;
    int          m_wd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [15:0] e_data;
        logic [7:0]  e_in, e_out;
        logic [4:0]  e_ctl;
        e_data = 16'd0; e_in = 8'd0; e_out = 8'd0; e_ctl = 5'd0;
        if (m_core) begin
            e_data = core_ext_data; e_in = core_reg_in_en; e_out = core_reg_out_en;
            e_ctl  = {core_ext_data_en, core_alu_reg_en, core_alu_sel, core_alu_out_en, core_g_reg_en};
        end else if (m_ph == 1) begin
            if (dbg_we) begin
                e_data = dbg_wdata; e_in = 8'd1 << dbg_reg; e_ctl = 5'b10000;
            end else begin
                e_out = 8'd1 << dbg_reg;
            end
        end
        chk("core_gnt",    32'(core_gnt), 32'(m_core));
        chk("dbg_ack",     32'(dbg_ack),  32'(m_ph == 2));
        chk("dbg_rdata",   32'(dbg_rdata), 32'(m_rdata));
        chk("wdog_err",    32'(wdog_err), 32'(m_wderr));
        chk("dp_ext_data", 32'(dp_ext_data), 32'(e_data));
        chk("dp_reg_in",   32'(dp_reg_in_en), 32'(e_in));
        chk("dp_reg_out",  32'(dp_reg_out_en), 32'(e_out));
        chk("dp_ctl",      32'({dp_ext_data_en, dp_alu_reg_en, dp_alu_sel, dp_alu_out_en, dp_g_reg_en}), 32'(e_ctl));
    endtask

    task automatic model_step();
        if (rst) begin
            m_core = 0; m_ph = 0; m_burst = 0; m_rdata = 16'd0; m_wderr = 0; m_wd = 0;
            return;
        end
        m_wderr = 0;
        if (m_core) begin
            if (core_last) begin
                m_burst = 0; m_wd = 0;
                if (dbg_req) begin m_core = 0; m_ph = 1; end
                else if (!core_req) m_core = 0;
            end else begin
`ifdef ARB_WATCHDOG_EN
                m_wd++;
                if (m_wd >= WDOG_CYCLES) begin
                    m_core = 0; m_burst = 0; m_wderr = 1; m_wd = 0;
                end
`endif
            end
        end else if (m_ph == 1) begin
            if (!dbg_we) m_rdata = dp_bus;
            m_burst = (m_burst < 15) ? m_burst + 1 : 15;
            m_ph = 2;
        end else begin
            m_ph = 0;
            if (dbg_req && (m_burst < DBG_BURST || !core_req)) m_ph = 1;
            else if (core_req) begin m_core = 1; m_wd = 0; end
        end
    endtask

    // Inputs are set after the falling edge; check, then advance model.
    task automatic tick();
        #1;
        if (chk_en) check_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic rand_core_ctl();
        core_ext_data    = 16'($urandom);
        core_ext_data_en = 1'($urandom);
        core_alu_reg_en  = 1'($urandom);
        core_alu_sel     = 1'($urandom);
        core_alu_out_en  = 1'($urandom);
        core_g_reg_en    = 1'($urandom);
        core_reg_in_en   = 8'($urandom);
        core_reg_out_en  = 8'($urandom);
        dp_bus           = 16'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int acks, gcnt, errs;
        bit seen_core, was_gnt, cont;
        bit c_pend, d_pend;
        int c_len, c_cnt;

        // ---- reset with toggling inputs ----
        rst = 1'b1;
        core_req = 0; core_last = 0; dbg_req = 0; dbg_we = 0; dbg_reg = 0; dbg_wdata = 0;
        rand_core_ctl();
        tick();
        chk_en = 1;
        core_req = 1'($urandom); core_last = 1'($urandom); dbg_req = 1'($urandom);
        dbg_we = 1'($urandom); dbg_reg = 3'($urandom); dbg_wdata = 16'($urandom);
        rand_core_ctl();
        tick();
        rst = 1'b0;
        core_req = 0; core_last = 0; dbg_req = 0;

        // ---- debug write from idle ----
        dbg_req = 1; dbg_we = 1; dbg_reg = 3'd5; dbg_wdata = 16'hBEEF;
        tick();
        #1;
        chk("wr_reg_in", 32'(dp_reg_in_en), 32'h20);
        chk("wr_ext_en", 32'(dp_ext_data_en), 32'd1);
        chk("wr_ext_data", 32'(dp_ext_data), 32'hBEEF);
        tick();
        chk("wr_ack", 32'(dbg_ack), 32'd1);
        dbg_req = 0;
        tick();

        // ---- debug read ----
        dbg_req = 1; dbg_we = 0; dbg_reg = 3'd3;
        tick();
        dp_bus = 16'h1234;
        #1;
        chk("rd_reg_out", 32'(dp_reg_out_en), 32'h08);
        tick();
        chk("rd_ack", 32'(dbg_ack), 32'd1);
        chk("rd_data", 32'(dbg_rdata), 32'h1234);
        dbg_req = 0; dp_bus = 16'h0;
        tick();
        chk("rd_hold", 32'(dbg_rdata), 32'h1234);

        // ---- debug request arriving mid-instruction ----
        core_req = 1;
        tick();
        dbg_req = 1; dbg_we = 1; dbg_reg = 3'd1; dbg_wdata = 16'h5A5A;
        rand_core_ctl();
        tick();
        rand_core_ctl();
        tick();
        rand_core_ctl(); core_last = 1; core_req = 0;
        tick();
        core_last = 0;
        #1;
        chk("mid_gnt_low", 32'(core_gnt), 32'd0);
        chk("mid_xfer", 32'(dp_reg_in_en), 32'h02);
        tick();
        dbg_req = 0;
        tick();

        // ---- burst limit: 2 acks then one instruction, repeating ----
        core_req = 1; dbg_req = 1;
        acks = 0; gcnt = 0; seen_core = 0;
        for (int i = 0; i < 40; i++) begin
            rand_core_ctl();
            dbg_we = 1'($urandom); dbg_reg = 3'($urandom); dbg_wdata = 16'($urandom);
            core_last = m_core && (gcnt == 1);
            #1;
            if (dbg_ack) acks++;
            if (core_gnt) begin
                if (core_last) begin
                    if (seen_core) chk("burst_acks", 32'(acks), 32'd2);
                    seen_core = 1; acks = 0; gcnt = 0;
                end else gcnt++;
            end
            tick();
        end
        dbg_req = 0;
        core_last = m_core && (gcnt == 1);
        tick();
        core_last = 0;

        // ---- core_last never arrives ----
        core_req = 1; errs = 0;
        for (int i = 0; i < 100; i++) begin
            rand_core_ctl();
            #1;
            if (wdog_err) errs++;
            tick();
        end
`ifdef ARB_WATCHDOG_EN
        chk("wdog_pulses", 32'(errs > 0), 32'd1);
`else
        chk("wdog_pulses", 32'(errs), 32'd0);
        chk("hold_gnt", 32'(core_gnt), 32'd1);
`endif
        core_req = 0; core_last = m_core;
        tick();
        core_last = 0;
        tick();

        // ---- randomized traffic with occasional reset ----
        c_pend = 0; d_pend = 0; c_len = 1; c_cnt = 0; cont = 0;
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(149) == 0);
            rand_core_ctl();
            if (!c_pend && $urandom_range(2) == 0) begin
                c_pend = 1; c_len = 1 + $urandom_range(3); c_cnt = 0;
            end
            was_gnt = m_core;
            core_req = c_pend; core_last = 1'($urandom);
            if (m_core && c_pend) begin
                core_last = (c_cnt + 1 == c_len);
                if (core_last) begin
                    cont = 1'($urandom);
                    core_req = cont;
                end
            end
            if (m_ph == 2) begin
                d_pend = 1'($urandom);
                dbg_we = 1'($urandom); dbg_reg = 3'($urandom); dbg_wdata = 16'($urandom);
            end else if (!d_pend) begin
                dbg_we = 1'($urandom); dbg_reg = 3'($urandom); dbg_wdata = 16'($urandom);
                if ($urandom_range(2) == 0) d_pend = 1;
            end
            dbg_req = d_pend;
            tick();
            if (rst) begin
                c_pend = 0; d_pend = 0; c_cnt = 0;
            end else if (was_gnt && c_pend) begin
                if (core_last) begin
                    c_pend = cont; c_len = 1 + $urandom_range(3); c_cnt = 0;
                end else c_cnt++;
            end
        end
        rst = 0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
